// File: rtl/grid_ram_arbiter.sv
// Occupancy-grid RAM arbiter: video reads, game read/write/claim, round clear.
// GRID_BORDER_WALL_EN makes the clear paint the playfield border as wall.
module grid_ram_arbiter #(
  parameter int GRID_W = 64,
  parameter int GRID_H = 48,
  parameter int DATA_W = 2,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [6:0]        vid_x,
  input  logic [5:0]        vid_y,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              game_req,
  input  logic [1:0]        game_op,
  input  logic [6:0]        game_x,
  input  logic [5:0]        game_y,
  input  logic [DATA_W-1:0] game_wdata,
  output logic              game_ack,
  output logic [DATA_W-1:0] game_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CLAIM_RD,
    CLAIM_EVAL,
    CLAIM_WR,
    WR,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [DATA_W-1:0] WALL = DATA_W'(3);

  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic ack_q, ack_n;
  logic ack_mem, ack_mem_n;
  logic done_q, done_n;
  logic vvalid;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic we_n;
  logic [DATA_W-1:0] wdata_n;
  logic [ADDR_W-1:0] vaddr, gaddr;
  logic in_range, free;
  logic [DATA_W-1:0] clr_val;

  assign vaddr = ADDR_W'(vid_y) * ADDR_W'(GRID_W)
               + ADDR_W'(vid_x);
  assign gaddr = ADDR_W'(game_y) * ADDR_W'(GRID_W)
               + ADDR_W'(game_x);
  assign in_range = (int'(game_x) < GRID_W)
                 && (int'(game_y) < GRID_H);
  assign free = !vid_req;

`ifdef GRID_BORDER_WALL_EN
  logic [ADDR_W-1:0] cx, cy;
  assign cx = cnt % ADDR_W'(GRID_W);
  assign cy = cnt / ADDR_W'(GRID_W);
  assign clr_val =
    (cx == '0 || cx == ADDR_W'(GRID_W - 1) ||
     cy == '0 || cy == ADDR_W'(GRID_H - 1))
    ? WALL : '0;
`else
  assign clr_val = '0;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ack_n     = 1'b0;
    ack_mem_n = 1'b0;
    done_n    = 1'b0;
    rdata_n   = rdata_q;
    addr_n    = vaddr;
    we_n      = 1'b0;
    wdata_n   = '0;
    unique case (state)
      IDLE: begin
        if (clr_start) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end else if (game_req && !ack_q) begin
          if (!in_range) begin
            ack_n   = 1'b1;
            rdata_n = WALL;
          end else begin
            unique case (game_op)
              2'b01:   state_n = WR;
              2'b10:   state_n = CLAIM_RD;
              default: state_n = RD;
            endcase
          end
        end
      end
      RD: if (free) begin
        addr_n    = gaddr;
        ack_n     = 1'b1;
        ack_mem_n = 1'b1;
        state_n   = IDLE;
      end
      WR: if (free) begin
        addr_n  = gaddr;
        we_n    = 1'b1;
        wdata_n = game_wdata;
        ack_n   = 1'b1;
        state_n = IDLE;
      end
      CLAIM_RD: if (free) begin
        addr_n  = gaddr;
        state_n = CLAIM_EVAL;
      end
      CLAIM_EVAL: begin
        if (mem_rdata == '0) begin
          state_n = CLAIM_WR;
        end else begin
          ack_n   = 1'b1;
          rdata_n = mem_rdata;
          state_n = IDLE;
        end
      end
      CLAIM_WR: if (free) begin
        addr_n  = gaddr;
        we_n    = 1'b1;
        wdata_n = game_wdata;
        ack_n   = 1'b1;
        rdata_n = '0;
        state_n = IDLE;
      end
      CLEAR: if (free) begin
        addr_n  = cnt;
        we_n    = 1'b1;
        wdata_n = clr_val;
        if (cnt == LAST) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ack_q   <= 1'b0;
      ack_mem <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      vvalid  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ack_q   <= ack_n;
      ack_mem <= ack_mem_n;
      done_q  <= done_n;
      rdata_q <= rdata_n;
      vvalid  <= vid_req;
    end
  end

  // RAM pins are forced idle while reset is held so an aborted op never writes
  assign mem_addr  = rst ? '0 : addr_n;
  assign mem_we    = rst ? 1'b0 : we_n;
  assign mem_wdata = rst ? '0 : wdata_n;

  assign vid_valid  = vvalid;
  assign vid_data   = vvalid ? mem_rdata : '0;
  assign game_ack   = ack_q;
  assign game_rdata = ack_mem ? mem_rdata : rdata_q;
  assign clr_busy   = (state == CLEAR);
  assign clr_done   = done_q;

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Directed bench for grid_ram_arbiter with a 1-cycle-latency RAM model.
module tb_grid_ram_arbiter;
  logic clk = 0;
  logic rst;
  logic vid_req;
  logic [6:0] vid_x;
  logic [5:0] vid_y;
  logic vid_valid;
  logic [1:0] vid_data;
  logic game_req;
  logic [1:0] game_op;
  logic [6:0] game_x;
  logic [5:0] game_y;
  logic [1:0] game_wdata;
  logic game_ack;
  logic [1:0] game_rdata;
  logic clr_start;
  logic clr_busy;
  logic clr_done;
  logic [11:0] mem_addr;
  logic mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;

  logic [1:0] ram [0:4095];
  int wr_cnt = 0;
  int total = 0;
  int bad = 0;

  grid_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_x(vid_x), .vid_y(vid_y),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .game_req(game_req), .game_op(game_op),
    .game_x(game_x), .game_y(game_y),
    .game_wdata(game_wdata), .game_ack(game_ack),
    .game_rdata(game_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic op(input logic [1:0] o,
                    input int x, input int y,
                    input logic [1:0] wd,
                    output int lat,
                    output logic [1:0] rd);
    tick();
    game_op = o;
    game_x = 7'(x);
    game_y = 6'(y);
    game_wdata = wd;
    game_req = 1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!game_ack && lat < 5000);
    rd = game_rdata;
    game_req = 0;
  endtask

  function automatic logic [1:0] clr_exp(input int a);
    int x, y;
    x = a % 64;
    y = a / 64;
`ifdef GRID_BORDER_WALL_EN
    if (x == 0 || x == 63 || y == 0 || y == 47)
      return 2'd3;
`endif
    return (x < 0 || y < 0) ? 2'd1 : 2'd0;
  endfunction

  // clr_start is raised in the current cycle; walk the clear to clr_done
  task automatic run_clear(input bit chk, output int n);
    logic [15:0] exp;
    clr_start = 1;
    n = 0;
    do begin
      tick();
      clr_start = 0;
      n++;
      if (chk && n <= 3072) begin
        exp = {1'b1, 1'b1, 12'(n - 1), clr_exp(n - 1)};
        check("clear_stream",
              {clr_busy, mem_we, mem_addr, mem_wdata}, exp);
      end
    end while (!clr_done && n < 4000);
  endtask

  task automatic check_reset_vals();
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_game_ack", game_ack, 0);
    check("rst_game_rdata", game_rdata, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  initial begin
    int lat, n, w0;
    logic [1:0] rd;
    int vx[5] = '{10, 11, 10, 0, 10};
    logic [1:0] vd[5] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1};

    rst = 1;
    vid_req = 0; vid_x = 3; vid_y = 2;
    game_req = 0; game_op = 0;
    game_x = 0; game_y = 0; game_wdata = 0;
    clr_start = 0;
    repeat (3) tick();
    check_reset_vals();
    rst = 0;

    // dirty a cell so the clear has something to erase
    op(2'b01, 5, 5, 2'd2, lat, rd);
    check("wr_lat", lat, 2);
    check("wr_ram", ram[325], 2);

    tick();
    run_clear(1, n);
    check("clr_cycles", n, 3073);
    check("clr_busy_drop", clr_busy, 0);
    tick();
    check("clr_done_pulse", clr_done, 0);

    op(2'b00, 5, 5, 2'd0, lat, rd);
    check("rd55_lat", lat, 2);
    check("rd55_data", rd, 0);

    w0 = wr_cnt;
    op(2'b10, 10, 10, 2'd1, lat, rd);
    check("claim_empty_lat", lat, 4);
    check("claim_empty_rd", rd, 0);
    check("claim_empty_wr", wr_cnt - w0, 1);
    check("claim_cell", ram[650], 1);

    w0 = wr_cnt;
    op(2'b10, 10, 10, 2'd2, lat, rd);
    check("claim_occ_lat", lat, 3);
    check("claim_occ_rd", rd, 1);
    check("claim_occ_nowr", wr_cnt - w0, 0);

    // video holds the port for cycles 1..5 of a claim
    tick();
    game_op = 2'b10; game_x = 10; game_y = 10;
    game_wdata = 2'd2; game_req = 1;
    w0 = wr_cnt;
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      lat++;
      if (i > 0) begin
        check("vid_valid", vid_valid, 1);
        check("vid_data", vid_data, vd[i-1]);
      end
      vid_req = 1;
      vid_x = 7'(vx[i]);
      vid_y = 10;
      #1;
      check("vid_owns", {mem_we, mem_addr},
            {1'b0, 12'(640 + vx[i])});
      check("ack_stalled", game_ack, 0);
    end
    tick();
    lat++;
    vid_req = 0;
    check("vid_valid_last", vid_valid, 1);
    check("vid_data_last", vid_data, vd[4]);
    while (!game_ack && lat < 50) begin
      tick();
      lat++;
    end
    check("stall_lat", lat, 8);
    check("stall_rd", game_rdata, 1);
    check("stall_nowr", wr_cnt - w0, 0);
    game_req = 0;
    tick();
    check("vid_valid_off", vid_valid, 0);

    w0 = wr_cnt;
    op(2'b10, 64, 0, 2'd1, lat, rd);
    check("oor_claim_lat", lat, 1);
    check("oor_claim_rd", rd, 3);
    op(2'b00, 0, 48, 2'd0, lat, rd);
    check("oor_rd_lat", lat, 1);
    check("oor_rd_rd", rd, 3);
    check("oor_nowr", wr_cnt - w0, 0);

    // clear and a write requested together: clear first
    tick();
    game_op = 2'b01; game_x = 20; game_y = 20;
    game_wdata = 2'd2; game_req = 1;
    run_clear(0, n);
    check("clr_wr_cycles", n, 3073);
    check("clr_wr_noack", game_ack, 0);
    tick();
    check("clr_wr_ack1", game_ack, 0);
    tick();
    check("clr_wr_ack2", game_ack, 1);
    game_req = 0;
    tick();
    check("clr_wr_kept", ram[1300], 2);

    // reset in the middle of a clear, then restart it
    clr_start = 1;
    for (int i = 0; i < 101; i++) begin
      tick();
      clr_start = 0;
    end
    check("mid_addr", mem_addr, 100);
    rst = 1;
    tick();
    check_reset_vals();
    rst = 0;
    tick();
    run_clear(1, n);
    check("reclr_cycles", n, 3073);
    op(2'b00, 0, 7, 2'd0, lat, rd);
`ifdef GRID_BORDER_WALL_EN
    check("edge_07", rd, 3);
`else
    check("edge_07", rd, 0);
`endif
    op(2'b00, 1, 7, 2'd0, lat, rd);
    check("inner_17", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/grid_ram_arbiter.md
Name: grid_ram_arbiter

Overview:
- Owns the single-port occupancy-grid RAM. One cell per 10x10 px tile of the 640x480 playfield.
- Shares the RAM between three users: the VGA renderer (read-only, absolute priority), the game logic (read/write/claim ops for trail drawing and collision detection), and an internal clear sequencer for round start.
- Sits between the VGA timing/pixel path and the game-state FSM. The RAM macro is external.

Parameters:
- GRID_W, 64, grid width in cells.
- GRID_H, 48, grid height in cells.
- DATA_W, 2, cell value width: 0 = empty, 1 = player 1, 2 = player 2, 3 = wall.
- ADDR_W, 12, RAM address width. Cell address = y*GRID_W + x.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- vid_req  in  1  renderer read request for this cycle.
- vid_x  in  7  renderer cell column.
- vid_y  in  6  renderer cell row.
- vid_valid  out  1  renderer read data valid.
- vid_data  out  DATA_W  renderer read data.
- game_req  in  1  game op request; held until game_ack.
- game_op  in  2  00 read, 01 write, 10 claim (test-and-set), 11 reserved (treated as read).
- game_x  in  7  game op column; stable while game_req is high.
- game_y  in  6  game op row; stable while game_req is high.
- game_wdata  in  DATA_W  value for write/claim.
- game_ack  out  1  one-cycle completion pulse.
- game_rdata  out  DATA_W  read result, or prior cell value for claim; valid with game_ack.
- clr_start  in  1  pulse: start grid clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear finishes.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; one-cycle latency.

Behaviour:
- Reset values: vid_valid = 0, vid_data = 0, game_ack = 0, game_rdata = 0, clr_busy = 0, clr_done = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. State = IDLE, clear counter = 0.
- Reset mid-operation aborts the op with no write and no ack. A pending game_req is re-serviced after reset release.
- Port ownership, per cycle:
  - If vid_req = 1, the video port owns the RAM: mem_addr = vid address, mem_we = 0. Any other access scheduled for that cycle stalls one cycle.
  - vid_valid is registered vid_req; vid_data = mem_rdata in the cycle after the request. Fixed latency 1, never stalled.
  - A "free cycle" is any cycle with vid_req = 0.
- FSM states: IDLE, RD, CLAIM_RD, CLAIM_EVAL, CLAIM_WR, WR, CLEAR.
- IDLE:
  - If clr_start = 1, go to CLEAR. Clear wins over a simultaneous game_req.
  - Else if game_req = 1, decode game_op.
  - Out-of-range cell (x >= GRID_W or y >= GRID_H): no RAM access; game_ack next cycle with game_rdata = 3.
- Read: in RD, issue the read on the first free cycle. Ack the following cycle with game_rdata = mem_rdata. Minimum latency req->ack = 2 cycles.
- Write: in WR, issue mem_we = 1 on the first free cycle. Ack the next cycle. Minimum latency 2 cycles.
- Claim:
  - CLAIM_RD issues the read on a free cycle.
  - CLAIM_EVAL samples mem_rdata.
  - If the sampled value = 0, go to CLAIM_WR: write game_wdata on a free cycle, then ack with game_rdata = 0.
  - If nonzero: ack the next cycle with game_rdata = prior value and no write.
  - Minimum latency: 4 cycles (empty cell), 3 cycles (occupied).
- After ack, return to IDLE. game_req must drop in the ack cycle. A request still high one cycle later is a new op.
- CLEAR:
  - clr_busy = 1 from the cycle after clr_start.
  - Writes 0 to addresses 0..GRID_W*GRID_H-1 (0..3071), one per free cycle, in ascending order.
  - After the last write: clr_done pulses 1 cycle, clr_busy drops the same cycle, FSM returns to IDLE.
  - With no video traffic, clr_start->clr_done = 3073 cycles.
  - clr_start while clr_busy = 1 or while a game op is in flight is ignored.
  - game_req during CLEAR waits; it is serviced after clr_done.
- Address arithmetic is done at ADDR_W bits; no wrap. Out-of-range coordinates are filtered before address formation.

Optional Feature:
- Macro: GRID_BORDER_WALL_EN.
- Defined: the clear writes 3 (wall) to every cell with x = 0, x = GRID_W-1, y = 0 or y = GRID_H-1, and 0 elsewhere. Cycle count is unchanged.
- Undefined: all cells are cleared to 0.

Test Plan:
- rst, then clr_start with vid_req = 0 -> clr_busy for 3072 writes, addresses 0..3071 with wdata 0, clr_done at cycle 3073. Read (5,5) -> game_rdata = 0.
- Claim (10,10) wdata = 1 on an empty grid -> ack at req+4, game_rdata = 0, cell now 1. Repeat the claim with wdata = 2 -> ack at req+3, game_rdata = 1, no mem_we.
- Claim (10,10) with vid_req held high for 5 cycles from the request -> no game access while vid_req = 1. vid_valid and vid_data correct every cycle; ack delayed by exactly 5 cycles.
- Claim (64,0) and read (0,48) -> no mem access, ack next cycle with game_rdata = 3.
- clr_start and game_req (write) in the same cycle -> clear runs first. Write acked after clr_done and not overwritten by the clear.
- rst asserted mid-clear at address 100 -> all outputs at reset values. A new clr_start restarts from address 0. With GRID_BORDER_WALL_EN defined: (0,7) reads 3 and (1,7) reads 0.
